fft_input_loader: RTL and testbench
===================================

FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001: Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst  input  1  asynchronous active-high reset.
REQ-004: en  input  1  global enable; low freezes all state and deasserts load_ready.
REQ-005: flush  input  1  synchronous discard of the partial or held frame.
REQ-006: load_valid  input  1  a sample is present on load_data.
REQ-007: load_data  input  8  {re[7:4], im[3:0]}, each field a 4-bit two's complement value.
REQ-008: load_ready  output  1  loader accepts a sample this cycle.
REQ-009: frame_valid  output  1  a complete 4-point frame is presented.
REQ-010: frame_ready  input  1  the downstream butterfly core accepts the frame.
REQ-011: frame_re  output  16  four real parts, slot i at bits [4i+3:4i].
REQ-012: frame_im  output  16  four imaginary parts, same slot layout as frame_re.
REQ-013: fill_level  output  3  number of samples held (0..4).

Function
REQ-014: States:
- FILL: collecting samples.
- HOLD: frame presented downstream.
REQ-015: A sample handshake occurs when load_valid, load_ready and en are all high.
REQ-016: load_ready SHALL be high only in FILL with en high.
REQ-017: Each sample handshake writes the sample into slot addr(count), then increments count.
REQ-018: After the 4th sample handshake, the FSM enters HOLD; frame_valid rises the next cycle (1-cycle latency).
REQ-019: In HOLD, frame_valid stays high and frame_re/frame_im stay stable until a frame handshake (frame_valid, frame_ready and en all high).
REQ-020: A frame handshake returns the FSM to FILL with count=0; load_ready rises the following cycle (no same-cycle reload).
REQ-021: load_valid in HOLD is ignored; no slot changes.
REQ-022: flush=1 with en=1 forces FILL and count=0, and drops frame_valid next cycle; flush takes priority over any simultaneous sample or frame handshake.
REQ-023: en=0 freezes state; frame_valid keeps its value; handshakes do not complete.
REQ-024: fill_level equals count in FILL and equals 4 in HOLD.
REQ-025: Slot contents are not cleared on frame handshake or flush; only count is reset.

Reset
REQ-026: rst=1 asynchronously forces the following, regardless of clk:
- FILL state, count=0;
- all slots to 0, so frame_re=0 and frame_im=0;
- frame_valid=0, load_ready=0, fill_level=0.
REQ-027: rst asserted mid-fill or in HOLD discards the frame entirely.
REQ-028: load_ready may rise on the first clk edge after rst deasserts, provided en=1.

Configuration
REQ-029: Macro FFT_LOADER_BITREV_EN selects slot ordering:
- defined: addr(k) = bit-reverse of the 2-bit k (0,2,1,3), matching radix-2 DIT input order;
- undefined: addr(k) = k (natural order), for a core that reorders internally.

Structure
REQ-030: Package fft_pkg holds:
- NUM_POINTS=4, SAMPLE_W=4, ADDR_W=2;
- typedef cplx_sample_t {re, im};
- the loader state enum.
REQ-031: Sub-module fft_bitrev_addr (combinational, ADDR_W-bit) computes addr(k); it is instantiated only when FFT_LOADER_BITREV_EN is defined.

Verification
REQ-032: Basic fill, BITREV_EN defined:
- stimulus: samples 0x11, 0x22, 0x33, 0x44, back-to-back, frame_ready=0;
- response: frame_valid high 1 cycle after the 4th sample; frame_re=0x4231, frame_im=0x4231; fill_level=4; load_ready=0.
REQ-033: Same stimulus with BITREV_EN undefined -> frame_re=0x4321, frame_im=0x4321.
REQ-034: Frame release:
- stimulus: in HOLD, load_valid=1 with load_data=0x77 for 3 cycles, then frame_ready=1 for 1 cycle;
- response: frame unchanged during HOLD; FILL with fill_level=0 next cycle; load_ready=1 one cycle after that.
REQ-035: Flush:
- stimulus: load 2 samples, then flush=1 together with load_valid=1 and data 0x55;
- response: fill_level=0; 0x55 not counted; the next 4 samples form a fresh frame.
REQ-036: Reset and enable:
- rst pulse (not clock-aligned) mid-fill at fill_level=3: outputs go to 0 immediately;
- en=0 with load_valid=1 for 5 cycles: fill_level unchanged.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, sample type and loader state for the 4-point FFT input path.
package fft_pkg;
    localparam int NUM_POINTS = 4;
    localparam int SAMPLE_W   = 4;
    localparam int ADDR_W     = 2;
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_sample_t;
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } loader_state_t;
endpackage

// File: rtl/fft_bitrev_addr.sv
// fft_bitrev_addr: combinational bit reversal of a sample index into its slot address.
module fft_bitrev_addr
    import fft_pkg::*;
#(
    parameter int W = ADDR_W
) (
    input  logic [W-1:0] i_k,
    output logic [W-1:0] o_addr
);
    for (genvar i = 0; i < W; i++) begin : g_rev
        assign o_addr[i] = i_k[W-1-i];
    end
endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: collects four complex samples into a frame and holds it for the butterfly core.
// FFT_LOADER_BITREV_EN selects bit-reversed slot order; natural order when undefined.
module fft_input_loader
    import fft_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [15:0] frame_re,
    output logic [15:0] frame_im,
    output logic [2:0]  fill_level
);
    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_count;
    logic              r_rdy;
    cplx_sample_t      r_slot [NUM_POINTS];
    logic [ADDR_W-1:0] w_addr;
    logic              w_load_hs;
    logic              w_frame_hs;
    logic              w_last;

    assign load_ready  = en && r_rdy && (r_state == ST_FILL);
    assign frame_valid = (r_state == ST_HOLD);
    assign w_load_hs   = load_valid && load_ready && !flush;
    assign w_frame_hs  = frame_valid && frame_ready && en && !flush;
    assign w_last      = w_load_hs && (r_count == ADDR_W'(NUM_POINTS - 1));
    assign fill_level  = frame_valid ? 3'(NUM_POINTS) : {1'b0, r_count};

`ifdef FFT_LOADER_BITREV_EN
    fft_bitrev_addr #(.W(ADDR_W)) u_bitrev (
        .i_k    (r_count),
        .o_addr (w_addr)
    );
`else
    assign w_addr = r_count;
`endif

    // r_rdy lags FILL entry by one cycle so a released or flushed frame never reloads in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_count <= '0;
            r_rdy   <= 1'b0;
        end else if (en) begin
            r_rdy <= (r_state == ST_FILL) && !w_last;
            if (flush || w_frame_hs) begin
                r_state <= ST_FILL;
                r_count <= '0;
            end else if (w_load_hs) begin
                r_count <= r_count + 1'b1;
                if (w_last) r_state <= ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_POINTS; i++) r_slot[i] <= '0;
        end else if (w_load_hs) begin
            r_slot[w_addr] <= cplx_sample_t'(load_data);
        end
    end

    always_comb begin
        frame_re = '0;
        frame_im = '0;
        for (int i = 0; i < NUM_POINTS; i++) begin
            frame_re[SAMPLE_W*i +: SAMPLE_W] = r_slot[i].re;
            frame_im[SAMPLE_W*i +: SAMPLE_W] = r_slot[i].im;
        end
    end
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: vector table, corner sequences and randomized run against a frame-level model.
module tb_fft_input_loader;
    logic        clk = 1'b0;
    logic        rst, en, flush, load_valid, frame_ready;
    logic [7:0]  load_data;
    logic        load_ready, frame_valid;
    logic [15:0] frame_re, frame_im;
    logic [2:0]  fill_level;

    int n_pass = 0;
    int n_total = 0;

`ifdef FFT_LOADER_BITREV_EN
    localparam logic [15:0] FA = 16'h4231, FB_RE = 16'hDBCA, FB_IM = 16'h4231;
`else
    localparam logic [15:0] FA = 16'h4321, FB_RE = 16'hDCBA, FB_IM = 16'h4321;
`endif

    fft_input_loader dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .flush       (flush),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_re    (frame_re),
        .frame_im    (frame_im),
        .fill_level  (fill_level)
    );

    always #5 clk = ~clk;

    // frame-level model: a held flag, samples taken so far, and the four slot bytes
    bit       m_hold;
    bit       m_fresh;
    int       m_cnt;
    bit [7:0] m_slot [4];

    function automatic int slot_of(int k);
`ifdef FFT_LOADER_BITREV_EN
        return ((k % 2) * 2) + (k / 2);
`else
        return k;
`endif
    endfunction

    task automatic model_reset();
        m_hold = 0;
        m_fresh = 1;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) m_slot[i] = 8'h00;
    endtask

    task automatic model_update(input logic e, f, lv, input logic [7:0] d, input logic fr);
        bit ready;
        if (!e) return;
        ready = !m_hold && !m_fresh;
        if (f) begin
            m_fresh = m_hold;
            m_hold = 0;
            m_cnt = 0;
        end else if (m_hold) begin
            if (fr) begin
                m_hold = 0;
                m_cnt = 0;
                m_fresh = 1;
            end
        end else begin
            m_fresh = 0;
            if (lv && ready) begin
                m_slot[slot_of(m_cnt)] = d;
                m_cnt++;
                if (m_cnt == 4) m_hold = 1;
            end
        end
    endtask

    function automatic logic [15:0] m_re();
        logic [15:0] v = '0;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = m_slot[i][7:4];
        return v;
    endfunction

    function automatic logic [15:0] m_im();
        logic [15:0] v = '0;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = m_slot[i][3:0];
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic mcheck(input string tag);
        check({tag, ".frame_valid"}, 16'(frame_valid), 16'(m_hold));
        check({tag, ".fill_level"}, 16'(fill_level), m_hold ? 16'd4 : 16'(m_cnt));
        check({tag, ".load_ready"}, 16'(load_ready), 16'(en && !m_hold && !m_fresh));
        check({tag, ".frame_re"}, frame_re, m_re());
        check({tag, ".frame_im"}, frame_im, m_im());
    endtask

    task automatic step(input logic e, f, lv, input logic [7:0] d, input logic fr);
        en = e;
        flush = f;
        load_valid = lv;
        load_data = d;
        frame_ready = fr;
        @(posedge clk);
        model_update(e, f, lv, d, fr);
        #1;
    endtask

    typedef struct {
        logic        e, f, lv;
        logic [7:0]  d;
        logic        fr;
        logic        xfv;
        logic [2:0]  xfl;
        logic        xlr;
        logic        cre;
        logic [15:0] xre, xim;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 3'd0, 1, 0, 16'h0, 16'h0};
        tbl[1]  = '{1, 0, 1, 8'h11, 0, 0, 3'd1, 1, 0, 16'h0, 16'h0};
        tbl[2]  = '{1, 0, 1, 8'h22, 0, 0, 3'd2, 1, 0, 16'h0, 16'h0};
        tbl[3]  = '{1, 0, 1, 8'h33, 0, 0, 3'd3, 1, 0, 16'h0, 16'h0};
        tbl[4]  = '{1, 0, 1, 8'h44, 0, 1, 3'd4, 0, 1, FA, FA};
        tbl[5]  = '{1, 0, 1, 8'h77, 0, 1, 3'd4, 0, 1, FA, FA};
        tbl[6]  = '{1, 0, 1, 8'h77, 0, 1, 3'd4, 0, 1, FA, FA};
        tbl[7]  = '{1, 0, 1, 8'h77, 0, 1, 3'd4, 0, 1, FA, FA};
        tbl[8]  = '{1, 0, 1, 8'h77, 1, 0, 3'd0, 0, 1, FA, FA};
        tbl[9]  = '{1, 0, 1, 8'h77, 0, 0, 3'd0, 1, 1, FA, FA};
        tbl[10] = '{1, 0, 0, 8'h00, 0, 0, 3'd0, 1, 1, FA, FA};

        rst = 1;
        en = 0;
        flush = 0;
        load_valid = 0;
        load_data = '0;
        frame_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.frame_valid", 16'(frame_valid), 16'd0);
        check("reset.load_ready", 16'(load_ready), 16'd0);
        check("reset.fill_level", 16'(fill_level), 16'd0);
        check("reset.frame_re", frame_re, 16'h0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].e, tbl[i].f, tbl[i].lv, tbl[i].d, tbl[i].fr);
            check($sformatf("tbl%0d.frame_valid", i), 16'(frame_valid), 16'(tbl[i].xfv));
            check($sformatf("tbl%0d.fill_level", i), 16'(fill_level), 16'(tbl[i].xfl));
            check($sformatf("tbl%0d.load_ready", i), 16'(load_ready), 16'(tbl[i].xlr));
            if (tbl[i].cre) begin
                check($sformatf("tbl%0d.frame_re", i), frame_re, tbl[i].xre);
                check($sformatf("tbl%0d.frame_im", i), frame_im, tbl[i].xim);
            end
            mcheck($sformatf("tbl%0d.model", i));
        end

        // flush mid-fill wins over the simultaneous sample
        step(1, 0, 1, 8'h11, 0);
        step(1, 0, 1, 8'h22, 0);
        check("flush.pre_level", 16'(fill_level), 16'd2);
        step(1, 1, 1, 8'h55, 0);
        check("flush.level", 16'(fill_level), 16'd0);
        check("flush.ready", 16'(load_ready), 16'd1);
        mcheck("flush");
        step(1, 0, 1, 8'hA1, 0);
        step(1, 0, 1, 8'hB2, 0);
        step(1, 0, 1, 8'hC3, 0);
        step(1, 0, 1, 8'hD4, 0);
        check("flush.new_valid", 16'(frame_valid), 16'd1);
        check("flush.new_re", frame_re, FB_RE);
        check("flush.new_im", frame_im, FB_IM);
        step(1, 1, 0, 8'h00, 1);
        check("flush_hold.valid", 16'(frame_valid), 16'd0);
        check("flush_hold.ready", 16'(load_ready), 16'd0);
        mcheck("flush_hold");
        step(1, 0, 0, 8'h00, 0);
        check("flush_hold.ready_next", 16'(load_ready), 16'd1);

        // asynchronous reset mid-fill, away from any clock edge
        step(1, 0, 1, 8'h61, 0);
        step(1, 0, 1, 8'h72, 0);
        step(1, 0, 1, 8'h83, 0);
        check("arst.pre_level", 16'(fill_level), 16'd3);
        #2 rst = 1;
        #1;
        check("arst.level", 16'(fill_level), 16'd0);
        check("arst.valid", 16'(frame_valid), 16'd0);
        check("arst.ready", 16'(load_ready), 16'd0);
        check("arst.re", frame_re, 16'h0);
        check("arst.im", frame_im, 16'h0);
        model_reset();
        @(negedge clk);
        rst = 0;
        step(1, 0, 0, 8'h00, 0);
        check("arst.ready_after", 16'(load_ready), 16'd1);

        // enable low freezes everything
        step(1, 0, 1, 8'h19, 0);
        step(1, 0, 1, 8'h2A, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 8'h99, 0);
            check($sformatf("en_off%0d.level", i), 16'(fill_level), 16'd2);
            check($sformatf("en_off%0d.ready", i), 16'(load_ready), 16'd0);
        end
        step(1, 0, 0, 8'h00, 0);
        check("en_on.ready", 16'(load_ready), 16'd1);
        mcheck("en_on");

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 9) < 4));
            mcheck($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
